// File: rtl/stream_pkt_pkg.sv
// Shared types for the packet ingress tagger and the packet FIFO.
package stream_pkt_pkg;

    typedef enum logic [0:0] {
        ST_PASS    = 1'b0,
        ST_DISCARD = 1'b1
    } pkt_tag_state_t;

    localparam int PKT_MAX_BEATS_DEFAULT = 14;

    // Counter width able to hold 0..max_beats inclusive.
    function automatic int pkt_beats_w(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

    typedef logic [$clog2(PKT_MAX_BEATS_DEFAULT + 1)-1:0] pkt_beats_t;

endpackage

// File: rtl/stream_pkt_tagger.sv
// Packet ingress tagger: counts beats, truncates at MAX_PKT_BEATS, flags drops.
// Optional runt drop enabled by defining STREAM_PKT_TAGGER_RUNT_DROP_EN.
module stream_pkt_tagger
    import stream_pkt_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_PKT_BEATS = 14,
    parameter int MIN_PKT_BEATS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  s_err,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [DATA_WIDTH-1:0] m_header,
    output logic                  m_drop,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int CNT_W = pkt_beats_w(MAX_PKT_BEATS);
    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_PKT_BEATS);

    initial begin
        if (MAX_PKT_BEATS >= (2 ** DATA_WIDTH))
            $fatal(1, "MAX_PKT_BEATS must be below 2**DATA_WIDTH");
        if (MIN_PKT_BEATS < 1 || MIN_PKT_BEATS > MAX_PKT_BEATS)
            $fatal(1, "MIN_PKT_BEATS out of range");
    end

    pkt_tag_state_t   state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n;
    logic             err_seen;
    logic             at_max;
    logic             trunc;
    logic             last_out;
    logic             runt;

    assign n        = cnt + 1'b1;
    assign at_max   = (n == MAX_N);
    assign trunc    = at_max & ~s_last;
    assign last_out = s_last | at_max;

`ifdef STREAM_PKT_TAGGER_RUNT_DROP_EN
    localparam logic [CNT_W-1:0] MIN_N = CNT_W'(MIN_PKT_BEATS);
    assign runt = last_out & ~trunc & (n < MIN_N);
`else
    assign runt = 1'b0;
`endif

    assign s_ready = ~rst & ((state == ST_DISCARD) | ~m_valid | m_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_PASS;
            cnt      <= '0;
            err_seen <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            m_header <= '0;
            m_drop   <= 1'b0;
            m_valid  <= 1'b0;
        end else begin
            // A completed handshake empties the register unless refilled below.
            if (m_valid && m_ready)
                m_valid <= 1'b0;
            if (s_valid && s_ready) begin
                if (state == ST_PASS) begin
                    m_data   <= s_data;
                    m_last   <= last_out;
                    m_header <= DATA_WIDTH'(n);
                    m_drop   <= err_seen | s_err | trunc | runt;
                    m_valid  <= 1'b1;
                    if (last_out) begin
                        cnt      <= '0;
                        err_seen <= 1'b0;
                    end else begin
                        cnt      <= n;
                        err_seen <= err_seen | s_err;
                    end
                    if (trunc)
                        state <= ST_DISCARD;
                end else if (s_last) begin
                    state <= ST_PASS;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_pkt_tagger.sv
// Directed self-checking bench for stream_pkt_tagger (DATA_WIDTH=8, MAX=14, MIN=4).
module tb_stream_pkt_tagger;

`ifdef STREAM_PKT_TAGGER_RUNT_DROP_EN
    localparam logic RUNT = 1'b1;
`else
    localparam logic RUNT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_last, s_err, s_valid, s_ready;
    logic [7:0] m_data, m_header;
    logic       m_last, m_drop, m_valid, m_ready;

    int vectors = 0;
    int miscompares = 0;

    stream_pkt_tagger #(.DATA_WIDTH(8), .MAX_PKT_BEATS(14), .MIN_PKT_BEATS(4)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_last(s_last), .s_err(s_err), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_last(m_last), .m_header(m_header), .m_drop(m_drop),
        .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic l, input logic e);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        s_err   = e;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_err   = 1'b0;
    endtask

    // Sends len beats (m_ready=1); first exp_out beats must come out one cycle later.
    task automatic send_pkt(input string name, input logic [7:0] base, input int len,
                            input int err_at, input int exp_out, input logic exp_drop);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d = base + 8'(i);
            drive(d, i == len - 1, i == err_at);
            tick();
            if (i < exp_out) begin
                chk($sformatf("%s valid[%0d]", name, i), 32'(m_valid), 32'd1);
                chk($sformatf("%s data[%0d]", name, i), 32'(m_data), 32'(d));
                chk($sformatf("%s last[%0d]", name, i), 32'(m_last), 32'(i == exp_out - 1));
                if (i == exp_out - 1) begin
                    chk($sformatf("%s header", name), 32'(m_header), 32'(exp_out));
                    chk($sformatf("%s drop", name), 32'(m_drop), 32'(exp_drop));
                end
            end else begin
                chk($sformatf("%s swallowed[%0d]", name, i), 32'(m_valid), 32'd0);
                chk($sformatf("%s discard ready[%0d]", name, i), 32'(s_ready), 32'd1);
            end
        end
    endtask

    initial begin
        rst = 1'b1; m_ready = 1'b1; s_data = '0;
        idle();
        tick(); tick();
        chk("reset m_valid", 32'(m_valid), 32'd0);
        chk("reset m_last", 32'(m_last), 32'd0);
        chk("reset m_drop", 32'(m_drop), 32'd0);
        chk("reset m_header", 32'(m_header), 32'd0);
        chk("reset s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-reset s_ready", 32'(s_ready), 32'd1);

        // Clean packet then back-to-back packet: valid every cycle means no bubble.
        send_pkt("clean", 8'h10, 5, -1, 5, 1'b0);
        send_pkt("b2b", 8'h20, 5, -1, 5, 1'b0);
        idle(); tick();
        chk("idle m_valid", 32'(m_valid), 32'd0);

        send_pkt("err_mid", 8'h30, 6, 1, 6, 1'b1);
        send_pkt("oversize", 8'h40, 20, -1, 14, 1'b1);
        send_pkt("after_trunc", 8'h60, 1, -1, 1, RUNT);
        send_pkt("exact_max", 8'h00, 14, -1, 14, 1'b0);
        send_pkt("runt", 8'hA0, 2, -1, 2, RUNT);
        send_pkt("err_on_last", 8'hB0, 4, 3, 4, 1'b1);
        idle(); tick();
        chk("idle2 m_valid", 32'(m_valid), 32'd0);

        // Backpressure: outputs must hold while stalled.
        m_ready = 1'b0;
        drive(8'h70, 1'b0, 1'b0);
        #1;
        chk("bp ready empty", 32'(s_ready), 32'd1);
        tick();
        chk("bp v0", 32'(m_valid), 32'd1);
        chk("bp d0", 32'(m_data), 32'h70);
        chk("bp ready full", 32'(s_ready), 32'd0);
        drive(8'h71, 1'b0, 1'b0);
        tick();
        chk("bp hold d", 32'(m_data), 32'h70);
        chk("bp hold v", 32'(m_valid), 32'd1);
        tick();
        chk("bp hold d2", 32'(m_data), 32'h70);
        chk("bp hold l2", 32'(m_last), 32'd0);
        m_ready = 1'b1;
        #1;
        chk("bp ready drain", 32'(s_ready), 32'd1);
        tick();
        chk("bp d1", 32'(m_data), 32'h71);
        m_ready = 1'b0;
        drive(8'h72, 1'b1, 1'b0);
        #1;
        chk("bp ready stall2", 32'(s_ready), 32'd0);
        tick();
        chk("bp hold d1", 32'(m_data), 32'h71);
        m_ready = 1'b1;
        tick();
        chk("bp d2", 32'(m_data), 32'h72);
        chk("bp last", 32'(m_last), 32'd1);
        chk("bp header", 32'(m_header), 32'd3);
        chk("bp drop", 32'(m_drop), 32'(RUNT));
        idle(); tick();
        chk("bp drained", 32'(m_valid), 32'd0);

        // Reset mid-packet, then a fresh packet counts from 1.
        drive(8'h80, 1'b0, 1'b0); tick();
        drive(8'h81, 1'b0, 1'b1); tick();
        chk("pre-rst valid", 32'(m_valid), 32'd1);
        idle(); rst = 1'b1;
        tick();
        chk("rst mid m_valid", 32'(m_valid), 32'd0);
        chk("rst mid s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        send_pkt("after_rst", 8'h90, 5, -1, 5, 1'b0);
        idle(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_pkt_tagger.md
# stream_pkt_tagger

Packet ingress stage that sits directly upstream of the packet FIFO. It turns a raw `last`-delimited stream with a per-beat error flag into the FIFO's write-side format: `data`, `last`, `header` and `drop`. It counts beats, truncates oversize packets at `MAX_PKT_BEATS`, and marks errored or truncated packets for discard. The FIFO can then rely on every packet being at most `MAX_PKT_BEATS` beats.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of the data and header fields.
- `MAX_PKT_BEATS`, 14: longest packet forwarded. Must equal the downstream FIFO's `MAX_PKT_BEATS`. Requires `MAX_PKT_BEATS < 2**DATA_WIDTH`; otherwise `$fatal` in `initial`.
- `MIN_PKT_BEATS`, 4: runt threshold, used only with the macro. Requires `1 <= MIN_PKT_BEATS <= MAX_PKT_BEATS`; otherwise `$fatal`.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `s_data` in DATA_WIDTH: input beat.
- `s_last` in 1: final beat of the packet.
- `s_err` in 1: error on this beat.
- `s_valid` in 1: input handshake valid.
- `s_ready` out 1: input handshake ready.
- `m_data` out DATA_WIDTH: registered beat.
- `m_last` out 1: final forwarded beat.
- `m_header` out DATA_WIDTH: forwarded beat count. Defined only when `m_valid & m_last`.
- `m_drop` out 1: discard this packet. Defined only when `m_valid & m_last`.
- `m_valid` out 1: output handshake valid.
- `m_ready` in 1: output handshake ready.

## Operation
- FSM states:
  - `ST_PASS`: forward beats.
  - `ST_DISCARD`: swallow the remainder of a truncated packet.
- Beat counter `cnt`, width `$clog2(MAX_PKT_BEATS+1)`. Holds the number of beats already forwarded in the current packet. Cleared after each forwarded last beat.
- Sticky `err_seen`. Set on any accepted `s_err` in `ST_PASS`; cleared with `cnt`.
- Each accepted beat in `ST_PASS` loads the output register. With `n = cnt+1`:
  - `m_data = s_data`.
  - `m_last = s_last | (n == MAX_PKT_BEATS)`.
  - `m_header = n`, zero-extended.
  - `m_drop = err_seen | s_err | trunc`, where `trunc = (n == MAX_PKT_BEATS) & ~s_last`.
- On `trunc`, go to `ST_DISCARD`.
- `ST_DISCARD`:
  - `s_ready = 1`; beats are consumed with no output.
  - `s_err` is ignored.
  - The accepted `s_last` returns the FSM to `ST_PASS` with `cnt = 0`.
- The block never emits a packet of zero beats. A packet of exactly `MAX_PKT_BEATS` beats ending on `s_last` is not truncated.

## Timing
- Reset values: `s_ready = 0` during reset; all outputs 0, `cnt = 0`, `err_seen = 0`, state `ST_PASS`.
- `s_ready` in `ST_PASS` is `~m_valid | m_ready` (combinational). In `ST_DISCARD` it is 1.
- Latency is 1 cycle from input acceptance to `m_valid`. Full throughput of 1 beat per cycle under continuous `m_ready`.
- Output stability: `m_*` hold while `m_valid & ~m_ready`. `m_valid` drops only after a handshake with no new accepted beat.
- Reset mid-packet discards the partial packet. The first beat accepted after reset starts a new packet.
- Simultaneous `s_err` and `s_last` on the same beat: `m_drop = 1` on that beat.

## Configuration
- `STREAM_PKT_TAGGER_RUNT_DROP_EN`
  - Defined: `m_drop` additionally asserts on a last beat when `n < MIN_PKT_BEATS` and `trunc` is 0.
  - Undefined: no runt check. `MIN_PKT_BEATS` is still range-checked but otherwise unused.

## Structure
- Shared package `stream_pkt_pkg` holds:
  - the state enum type `pkt_tag_state_t`;
  - a `pkt_beats_t` width helper based on `MAX_PKT_BEATS`, usable by the FIFO and the tagger.
- No sub-module. The output register and FSM sit in one `always_ff`; `s_ready` is a single `assign`.

## Test plan
All scenarios use `DATA_WIDTH=8`, `MAX_PKT_BEATS=14`, `MIN_PKT_BEATS=4`.
- Clean packet: 5 beats `0x10..0x14`, no error, `m_ready=1` -> same 5 beats one cycle later; last beat `m_header=5`, `m_drop=0`. Back-to-back packets show no bubble.
- Error mid-packet: 6 beats with `s_err` on beat 2 -> 6 beats out; last beat `m_drop=1`, `m_header=6`.
- Oversize: 20-beat packet -> 14 beats out; beat 14 has `m_last=1`, `m_drop=1`, `m_header=14`. Beats 15–20 are accepted with no output. The next packet starts with `m_header` counting from 1.
- Exact max: 14 beats with `s_last` on beat 14 -> `m_drop=0`, `m_header=14`, no discard state entered.
- Backpressure and reset: random `m_ready` toggling yields byte-exact output with `m_*` stable while stalled. `rst` asserted mid-packet gives `m_valid=0` the next cycle, then a fresh packet after reset has `m_header` equal to its own length.
- Runt, macro defined: 2-beat clean packet -> `m_drop=1`, `m_header=2`. Macro undefined: `m_drop=0`.
